// File: rtl/mult_div_unit_if.sv
// Request/result bundle for mult_div_unit: operands and op in, Hi/Lo write strobes and data out.
// The unit drives State so checkers can follow the sequencer.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    // Start is a bare request sampled only while Busy is low; there is no ready or
    // acknowledge, so a Start seen while Busy is high (or with an invalid Op) is dropped.
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HiIn;
    logic [WIDTH-1:0] LoIn;
    logic             Busy;
    logic             WriteHi;
    logic             WriteLo;
    logic [WIDTH-1:0] WriteData1;
    logic [WIDTH-1:0] WriteData2;
    logic [1:0]       State;

    modport master (
        output Start, Op, A, B, HiIn, LoIn,
        input  Busy, WriteHi, WriteLo, WriteData1, WriteData2, State
    );

    modport slave (
        input  Start, Op, A, B, HiIn, LoIn,
        output Busy, WriteHi, WriteLo, WriteData1, WriteData2, State
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine producing Hi/Lo with a one-cycle write strobe.
// Optional MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulating into {HiIn,LoIn}.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            Clk,
    input logic            Reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic             busy_r;
    logic             write_r;
    logic [WIDTH-1:0] data1_r;
    logic [WIDTH-1:0] data2_r;

`ifdef MULDIV_MADD_EN
    logic [2*WIDTH-1:0] acc;
    logic               is_acc;
    logic               acc_sub;
`else
    logic               unused_acc_in;
    assign unused_acc_in = ^{bus.HiIn, bus.LoIn};
`endif

    // Request decode
    logic             op_valid;
    logic             op_signed;
    logic             op_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             start_ok;

    always_comb begin
`ifdef MULDIV_MADD_EN
        op_valid = 1'b1;
`else
        op_valid = ~bus.Op[2];
`endif
        op_signed = ~bus.Op[0];
        op_div    = (bus.Op[2:1] == 2'b01);
        a_neg     = op_signed & bus.A[WIDTH-1];
        b_neg     = op_signed & bus.B[WIDTH-1];
        a_abs     = a_neg ? (~bus.A + 1'b1) : bus.A;
        b_abs     = b_neg ? (~bus.B + 1'b1) : bus.B;
        start_ok  = (state == IDLE) & bus.Start & op_valid;
    end

    // One iteration of each algorithm, evaluated from the working registers
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_mag});
    end

    // Sign correction and optional accumulation
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [2*WIDTH-1:0] mul_result;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_mag = {work_hi, work_lo};
        prod_fix = neg_res ? (~prod_mag + 1'b1) : prod_mag;
`ifdef MULDIV_MADD_EN
        if (is_acc) begin
            mul_result = acc_sub ? (acc - prod_fix) : (acc + prod_fix);
        end else begin
            mul_result = prod_fix;
        end
`else
        mul_result = prod_fix;
`endif
        quo_fix = neg_res ? (~work_lo + 1'b1) : work_lo;
        rem_fix = neg_rem ? (~work_hi + 1'b1) : work_hi;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            busy_r   <= 1'b0;
            write_r  <= 1'b0;
            data1_r  <= '0;
            data2_r  <= '0;
`ifdef MULDIV_MADD_EN
            acc      <= '0;
            is_acc   <= 1'b0;
            acc_sub  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    write_r <= 1'b0;
                    if (start_ok) begin
                        state    <= RUN;
                        busy_r   <= 1'b1;
                        count    <= '0;
                        is_div   <= op_div;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (bus.B == '0);
                        a_raw    <= bus.A;
                        a_mag    <= a_abs;
                        b_mag    <= b_abs;
                        work_hi  <= '0;
                        // Multiply shifts the multiplier out of work_lo; divide shifts the dividend out.
                        work_lo  <= op_div ? a_abs : b_abs;
`ifdef MULDIV_MADD_EN
                        acc      <= {bus.HiIn, bus.LoIn};
                        is_acc   <= bus.Op[2];
                        acc_sub  <= bus.Op[1];
`endif
                    end
                end
                RUN: begin
                    if (is_div) begin
                        work_hi <= div_ge ? (div_shift[WIDTH-1:0] - b_mag) : div_shift[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], div_ge};
                    end else begin
                        work_hi <= mul_sum[WIDTH:1];
                        work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (div_zero) begin
                            data1_r <= a_raw;
                            data2_r <= '1;
                        end else begin
                            data1_r <= rem_fix;
                            data2_r <= quo_fix;
                        end
                    end else begin
                        data1_r <= mul_result[2*WIDTH-1:WIDTH];
                        data2_r <= mul_result[WIDTH-1:0];
                    end
                    write_r <= 1'b1;
                    state   <= WB;
                end
                WB: begin
                    write_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    busy_r  <= 1'b0;
                    write_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy       = busy_r;
    assign bus.WriteHi    = write_r;
    assign bus.WriteLo    = write_r;
    assign bus.WriteData1 = data1_r;
    assign bus.WriteData2 = data2_r;
    assign bus.State      = state;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
// Build with +define+MULDIV_MADD_EN to exercise the accumulate ops.
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural definition of each op
  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] hi_in,
                                           input logic [W-1:0] lo_in);
    longint sa, sb, sp, sq, sr;
    logic [63:0] p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (op[2:1] == 2'b01) begin
      if (b == 0) return {a, {W{1'b1}}};
      if (op[0] == 1'b0) begin
        sq = sa / sb;
        sr = sa % sb;
        q = sq;
        r = sr;
      end else begin
        q = {32'h0, a / b};
        r = {32'h0, a % b};
      end
      return {r[W-1:0], q[W-1:0]};
    end
    if (op[0] == 1'b0) begin
      sp = sa * sb;
      p = sp;
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    if (op[2]) p = op[1] ? ({hi_in, lo_in} - p) : ({hi_in, lo_in} + p);
    return p;
  endfunction

  task automatic drive_idle();
    bus.Start = 1'b0;
    bus.Op = 3'b000;
    bus.A = '0;
    bus.B = '0;
    bus.HiIn = '0;
    bus.LoIn = '0;
  endtask

  // Issue one op and watch it for WIDTH+4 cycles; optionally re-pulse Start at cycle repulse_c.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi_in,
                        input logic [W-1:0] lo_in, input int repulse_c);
    logic [2*W-1:0] exp_v;
    logic [2*W-1:0] got_v;
    int hi_strobes, lo_strobes, strobe_c, busy_bad_c;
    logic exp_busy;
    exp_q.push_back(model(op, a, b, hi_in, lo_in));
    hi_strobes = 0;
    lo_strobes = 0;
    strobe_c = -1;
    busy_bad_c = -1;
    got_v = '0;
    exp_v = '0;
    @(negedge clk);
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    bus.HiIn = hi_in;
    bus.LoIn = lo_in;
    bus.Start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= W + 3; c++) begin
      @(negedge clk);
      if (c == 0 || c == repulse_c + 1) bus.Start = 1'b0;
      if (c == repulse_c) begin
        bus.Start = 1'b1;
        bus.A = 32'd9;
        bus.B = $urandom;
        bus.HiIn = $urandom;
        bus.LoIn = $urandom;
      end
      exp_busy = (c <= W + 1);
      if (bus.Busy !== exp_busy && busy_bad_c < 0) busy_bad_c = c;
      if (bus.WriteHi === 1'b1) hi_strobes++;
      if (bus.WriteLo === 1'b1) lo_strobes++;
      if (bus.WriteHi === 1'b1 || bus.WriteLo === 1'b1) begin
        strobe_c = c;
        got_v = {bus.WriteData1, bus.WriteData2};
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          checks++;
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s result: got Hi=%h Lo=%h expected Hi=%h Lo=%h", name,
                     got_v[2*W-1:W], got_v[W-1:0], exp_v[2*W-1:W], exp_v[W-1:0]);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s no_write: got 0 strobes expected 1", name);
      exp_q.delete();
    end
    checks++;
    if (hi_strobes != 1 || lo_strobes != 1 || strobe_c != W + 1) begin
      errors++;
      $display("FAIL %s strobe: got hi=%0d lo=%0d at cycle %0d expected 1/1 at cycle %0d",
               name, hi_strobes, lo_strobes, strobe_c, W + 1);
    end
    checks++;
    if (busy_bad_c >= 0) begin
      errors++;
      $display("FAIL %s busy: wrong Busy at cycle %0d expected high through cycle %0d",
               name, busy_bad_c, W + 1);
    end
    checks++;
    if ({bus.WriteData1, bus.WriteData2} !== exp_v) begin
      errors++;
      $display("FAIL %s hold: got %h expected %h", name, {bus.WriteData1, bus.WriteData2}, exp_v);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.Busy, bus.WriteHi, bus.WriteLo} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000", {bus.Busy, bus.WriteHi, bus.WriteLo});
    end
    checks++;
    if ({bus.WriteData1, bus.WriteData2} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {bus.WriteData1, bus.WriteData2});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op("mult_neg",  3'b000, 32'hFFFFFFFD, 32'd7, '0, '0, -10);
    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, -10);
    run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'd2, '0, '0, -10);
    run_op("divu",      3'b011, 32'd7, 32'd2, '0, '0, -10);
    run_op("div_zero",  3'b010, 32'd5, 32'd0, '0, '0, -10);
    run_op("divu_zero", 3'b011, 32'hDEADBEEF, 32'd0, '0, '0, -10);
    run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, '0, '0, -10);
    run_op("div_negb",  3'b010, 32'd100, 32'hFFFFFFF9, '0, '0, -10);
  endtask

  task automatic test_busy_ignore();
    run_op("repulse_run", 3'b001, 32'd3, 32'd4, '0, '0, 5);
    run_op("repulse_wb",  3'b000, 32'd11, 32'hFFFFFFFE, '0, '0, W + 1);
  endtask

  task automatic test_reset_abort();
    int strobes;
    int busy_seen;
    @(negedge clk);
    bus.Op = 3'b001;
    bus.A = 32'd3;
    bus.B = 32'd4;
    bus.Start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.Start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.Busy, bus.WriteHi, bus.WriteLo} !== 3'b000 ||
        {bus.WriteData1, bus.WriteData2} !== 64'h0) begin
      errors++;
      $display("FAIL abort_clear: got busy/strobes %b data %h expected 000 and 0",
               {bus.Busy, bus.WriteHi, bus.WriteLo}, {bus.WriteData1, bus.WriteData2});
    end
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    busy_seen = 0;
    for (int c = 0; c < W + 6; c++) begin
      @(negedge clk);
      if (bus.WriteHi !== 1'b0 || bus.WriteLo !== 1'b0) strobes++;
      if (bus.Busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (strobes != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d strobe and %0d busy cycles expected 0 and 0",
               strobes, busy_seen);
    end
    run_op("after_abort", 3'b001, 32'd5, 32'd6, '0, '0, -10);
  endtask

`ifdef MULDIV_MADD_EN
  task automatic test_madd();
    run_op("maddu_wrap", 3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, -10);
    run_op("madd_neg",   3'b100, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd10, -10);
    run_op("msub",       3'b110, 32'd4, 32'hFFFFFFFF, 32'h1, 32'h0, -10);
    run_op("msubu",      3'b111, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h5, -10);
  endtask
`else
  task automatic test_invalid_op();
    int busy_seen;
    int strobes;
    busy_seen = 0;
    strobes = 0;
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      bus.Op = 3'(k);
      bus.A = $urandom;
      bus.B = $urandom;
      bus.Start = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        bus.Start = 1'b0;
        if (bus.Busy !== 1'b0) busy_seen++;
        if (bus.WriteHi !== 1'b0 || bus.WriteLo !== 1'b0) strobes++;
      end
    end
    checks++;
    if (busy_seen != 0 || strobes != 0) begin
      errors++;
      $display("FAIL invalid_op: got %0d busy and %0d strobe cycles expected 0 and 0",
               busy_seen, strobes);
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
`ifdef MULDIV_MADD_EN
      op = 3'($urandom_range(0, 7));
`else
      op = 3'($urandom_range(0, 3));
`endif
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = ~W'($urandom_range(0, 15));
        3: a = W'($urandom_range(0, 255));
        default: ;
      endcase
      run_op("random", op, a, b, $urandom, $urandom, -10);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", 3'b011, 32'hFFFFFFFF, 32'd3, '0, '0, -10);
    run_op("b2b_1", 3'b000, 32'h80000000, 32'h80000000, '0, '0, -10);
    run_op("b2b_2", 3'b010, 32'h80000000, 32'd1, '0, '0, -10);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
`ifdef MULDIV_MADD_EN
    test_madd();
`else
    test_invalid_op();
`endif
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
